peer_link: RTL and testbench
============================

# peer_link

Conditions the board-to-board handshake lines between two Sudoku FPGAs. Sits between the pmod pins and the game stage controller. Each raw `receive_*` input is synchronised, glitch-filtered and edge-detected. Each internal `send_*` request is stretched to a guaranteed minimum high time so the slower or unsynchronised peer always sees it.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flops in each input synchroniser, ≥2.
- `FILTER_CYCLES`, 16: consecutive stable cycles required before a filtered level changes, ≥1.
- `HOLD_CYCLES`, 1000: minimum high time of every `send_*` output after a request rising edge, ≥1.

Ports:
- `clk` in 1: system clock. One clock; all logic lives in this domain.
- `rst` in 1: reset, synchronous, active-high.
- `receive_connect`, `receive_start`, `receive_game_finish` in 1 each: raw asynchronous lines from the peer.
- `rx_connect`, `rx_start`, `rx_finish` out 1 each: filtered levels.
- `rx_connect_pulse`, `rx_start_pulse`, `rx_finish_pulse` out 1 each: one-cycle pulse on a filtered rising edge.
- `peer_lost` out 1: one-cycle pulse on a falling edge of `rx_connect`.
- `tx_connect_req`, `tx_start_req`, `tx_finish_req` in 1 each: internal request levels.
- `send_connect`, `send_start`, `send_game_finish` out 1 each: stretched lines to the peer.
- `link_up` out 1: equals `rx_connect & send_connect`.

## Operation
RX channel (three identical instances):
- Synchroniser shift chain of `SYNC_STAGES` flops; the last stage is `sync`.
- Filter holds a register `level` and a counter `cnt`, width clog2(`FILTER_CYCLES`+1).
- If `sync == level`: `cnt` ← 0.
- Else if `cnt == FILTER_CYCLES-1`: `level` ← `sync` and `cnt` ← 0.
- Else: `cnt` ← `cnt`+1.
- Pulse is registered: asserted in the same cycle `level` rises.
- `peer_lost` is asserted in the same cycle connect's `level` falls.

TX channel (three identical instances):
- `req_d` registers the request.
- Rising edge is `req & ~req_d`. On a rising edge, `hold` ← `HOLD_CYCLES-1`. Otherwise, if `hold != 0`, `hold` decrements.
- `send` ← `req | (rise ? 1 : hold != 0)`, registered.
- A retrigger during hold reloads `hold`. It never shortens the pulse.
- A held request keeps `send` high indefinitely. After release, `send` stays high until `hold` expires.
- Counter saturates at 0 with no wrap-around.

Reset:
- All synchroniser flops, `level`, `cnt`, `req_d`, `hold` and every output go to 0 on the edge where `rst` = 1.
- Reset mid-filter or mid-hold aborts it. The line drops on the next edge and emits no pulse.
- After reset, inputs that are already high are seen as new rising edges once filtered.

## Timing
- RX latency: call edge 1 the first clock edge that samples a new raw value. The filtered level and pulse update at edge `SYNC_STAGES+FILTER_CYCLES`. Default is 18 cycles.
- A raw glitch whose synchronised value differs for fewer than `FILTER_CYCLES` consecutive cycles never reaches `level`. No pulse is produced.
- TX latency: `send_*` rises 1 cycle after `req` rises.
- For a single-cycle `req`, `send` is high for exactly `HOLD_CYCLES` cycles.
- For `req` high N cycles, `send` is high for max(N, `HOLD_CYCLES`) cycles.
- Channels are fully independent. Simultaneous events on several lines are each handled the same as alone.
- `link_up` is combinational from registers, with no added latency.

## Structure
- Shared header holds the default constants: `PEER_SYNC_STAGES`, `PEER_FILTER_CYCLES`, `PEER_HOLD_CYCLES`.
- Sub-module `peer_link_rx_channel` contains sync, filter and edge detect, and is instantiated 3×.
- TX stretcher is a generate loop inside `peer_link`.
- Expected size is about 150–220 lines of RTL.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `FILTER_CYCLES`=4, `HOLD_CYCLES`=8.
- Raw `receive_start` 0→1 sampled at edge 1 and held → `rx_start` = 1 and `rx_start_pulse` = 1 for one cycle at edge 6. No second pulse while held.
- 3-cycle high glitch on `receive_game_finish` → `rx_finish` and `rx_finish_pulse` stay 0 throughout.
- `tx_connect_req` pulsed 1 cycle at edge 10 → `send_connect` high on edges 11–18 and low at edge 19.
- `tx_start_req` high at edge 10, again at edge 14 → `send_start` high edges 11–22 (retrigger extends).
- Filtered `rx_connect` = 1 and `tx_connect_req` held → `link_up` = 1. Drop `receive_connect` → `peer_lost` pulses once after 6 edges and `link_up` falls the same cycle.
- Assert `rst` during a hold (edge 13) → all outputs 0 at edge 13. With `req` low after reset, no `send` reassertion.

Source files
------------

// File: rtl/peer_link_pkg.sv
// Shared constants, channel indices and width helper for the board-to-board link.
package peer_link_pkg;

    localparam int PEER_SYNC_STAGES   = 2;
    localparam int PEER_FILTER_CYCLES = 16;
    localparam int PEER_HOLD_CYCLES   = 1000;
    localparam int PEER_NUM_CH        = 3;

    // Index of each handshake line inside the per-channel vectors.
    typedef enum logic [1:0] {
        CH_CONNECT = 2'd0,
        CH_START   = 2'd1,
        CH_FINISH  = 2'd2
    } peer_ch_e;

    // Width of a counter that must hold values 0..n (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        if (n < 1) begin
            return 1;
        end else begin
            return $clog2(n + 1);
        end
    endfunction

endpackage

// File: rtl/peer_link_rx_channel.sv
// One receive line: synchroniser chain, persistence filter and a registered
// change pulse. The parent decodes rise/fall from 'flip' and the new 'level'.
module peer_link_rx_channel
    import peer_link_pkg::*;
#(
    parameter int SYNC_STAGES   = PEER_SYNC_STAGES,
    parameter int FILTER_CYCLES = PEER_FILTER_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic flip
);

    localparam int            CW       = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] chain;
    logic                   sync;
    logic [CW-1:0]          cnt;

    assign sync = chain[SYNC_STAGES-1];

    // Shift the asynchronous line through the synchroniser flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], raw};
        end
    end

    // Accept a new level only after it has differed for FILTER_CYCLES cycles in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= '0;
            flip  <= 1'b0;
        end else begin
            flip <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync;
                cnt   <= '0;
                flip  <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/peer_link.sv
// Conditions the handshake lines between two boards: filtered, edge-detected
// receive lines and pulse-stretched send lines.
module peer_link
    import peer_link_pkg::*;
#(
    parameter int SYNC_STAGES   = PEER_SYNC_STAGES,
    parameter int FILTER_CYCLES = PEER_FILTER_CYCLES,
    parameter int HOLD_CYCLES   = PEER_HOLD_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic receive_connect,
    input  logic receive_start,
    input  logic receive_game_finish,
    output logic rx_connect,
    output logic rx_start,
    output logic rx_finish,
    output logic rx_connect_pulse,
    output logic rx_start_pulse,
    output logic rx_finish_pulse,
    output logic peer_lost,
    input  logic tx_connect_req,
    input  logic tx_start_req,
    input  logic tx_finish_req,
    output logic send_connect,
    output logic send_start,
    output logic send_game_finish,
    output logic link_up
);

    localparam int            HW        = cnt_width(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [PEER_NUM_CH-1:0] raw_vec;
    logic [PEER_NUM_CH-1:0] level_vec;
    logic [PEER_NUM_CH-1:0] flip_vec;
    logic [PEER_NUM_CH-1:0] req_vec;
    logic [PEER_NUM_CH-1:0] send_vec;

    assign raw_vec = {receive_game_finish, receive_start, receive_connect};
    assign req_vec = {tx_finish_req, tx_start_req, tx_connect_req};

    for (genvar i = 0; i < PEER_NUM_CH; i++) begin : g_rx
        peer_link_rx_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_rx (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_vec[i]),
            .level(level_vec[i]),
            .flip (flip_vec[i])
        );
    end

    for (genvar i = 0; i < PEER_NUM_CH; i++) begin : g_tx
        logic          req_d;
        logic [HW-1:0] hold;
        logic          send;
        logic          rise;

        assign rise        = req_vec[i] & ~req_d;
        assign send_vec[i] = send;

        // Stretch each request so the line stays high at least HOLD_CYCLES cycles.
        always_ff @(posedge clk) begin
            if (rst) begin
                req_d <= 1'b0;
                hold  <= '0;
                send  <= 1'b0;
            end else begin
                req_d <= req_vec[i];
                if (rise) begin
                    hold <= HOLD_LAST;
                    send <= 1'b1;
                end else begin
                    if (hold != '0) begin
                        hold <= hold - HW'(1);
                    end else begin
                        hold <= hold;
                    end
                    send <= req_vec[i] | (hold != '0);
                end
            end
        end
    end

    // The filter's flip flag marks the cycle the level changed; the new level tells the direction.
    assign rx_connect       = level_vec[CH_CONNECT];
    assign rx_start         = level_vec[CH_START];
    assign rx_finish        = level_vec[CH_FINISH];
    assign rx_connect_pulse = flip_vec[CH_CONNECT] &  level_vec[CH_CONNECT];
    assign rx_start_pulse   = flip_vec[CH_START]   &  level_vec[CH_START];
    assign rx_finish_pulse  = flip_vec[CH_FINISH]  &  level_vec[CH_FINISH];
    assign peer_lost        = flip_vec[CH_CONNECT] & ~level_vec[CH_CONNECT];

    assign send_connect     = send_vec[CH_CONNECT];
    assign send_start       = send_vec[CH_START];
    assign send_game_finish = send_vec[CH_FINISH];

    assign link_up = rx_connect & send_connect;

endmodule

// File: tb/tb_peer_link.sv
// Directed plus randomized bench for peer_link with a behavioural reference
// model built on raw-sample history windows and last-rise timestamps.
module tb_peer_link;

    localparam int S = 2;
    localparam int F = 4;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst;
    logic receive_connect, receive_start, receive_game_finish;
    logic rx_connect, rx_start, rx_finish;
    logic rx_connect_pulse, rx_start_pulse, rx_finish_pulse;
    logic peer_lost;
    logic tx_connect_req, tx_start_req, tx_finish_req;
    logic send_connect, send_start, send_game_finish;
    logic link_up;

    peer_link #(
        .SYNC_STAGES  (S),
        .FILTER_CYCLES(F),
        .HOLD_CYCLES  (H)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .receive_connect    (receive_connect),
        .receive_start      (receive_start),
        .receive_game_finish(receive_game_finish),
        .rx_connect         (rx_connect),
        .rx_start           (rx_start),
        .rx_finish          (rx_finish),
        .rx_connect_pulse   (rx_connect_pulse),
        .rx_start_pulse     (rx_start_pulse),
        .rx_finish_pulse    (rx_finish_pulse),
        .peer_lost          (peer_lost),
        .tx_connect_req     (tx_connect_req),
        .tx_start_req       (tx_start_req),
        .tx_finish_req      (tx_finish_req),
        .send_connect       (send_connect),
        .send_start         (send_start),
        .send_game_finish   (send_game_finish),
        .link_up            (link_up)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int edge_no = 0;

    // Reference model state, index 0 connect, 1 start, 2 finish.
    logic [31:0] hist [3];
    logic        m_level [3];
    logic        m_rise [3];
    logic        m_fall [3];
    logic        m_send [3];
    logic        prev_req [3];
    int          last_rise [3];

    function automatic logic [10:0] obs_vec();
        return {rx_connect, rx_start, rx_finish,
                rx_connect_pulse, rx_start_pulse, rx_finish_pulse,
                peer_lost, send_connect, send_start, send_game_finish, link_up};
    endfunction

    function automatic logic [10:0] exp_vec();
        return {m_level[0], m_level[1], m_level[2],
                m_rise[0], m_rise[1], m_rise[2],
                m_fall[0], m_send[0], m_send[1], m_send[2],
                m_level[0] & m_send[0]};
    endfunction

    // One clock: update the model from the inputs seen at this edge, then compare.
    task automatic tick();
        logic [2:0] raw;
        logic [2:0] req;
        logic [F-1:0] win;
        @(posedge clk);
        edge_no++;
        raw = {receive_game_finish, receive_start, receive_connect};
        req = {tx_finish_req, tx_start_req, tx_connect_req};
        for (int c = 0; c < 3; c++) begin
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            if (rst) begin
                hist[c]      = 32'd0;
                m_level[c]   = 1'b0;
                m_send[c]    = 1'b0;
                prev_req[c]  = 1'b0;
                last_rise[c] = -1000;
            end else begin
                hist[c] = {hist[c][30:0], raw[c]};
                win = hist[c][S+F-1:S];
                // Level flips once the last F synchronised samples all disagree with it.
                if (win == {F{~m_level[c]}}) begin
                    m_level[c] = ~m_level[c];
                    m_rise[c]  = m_level[c];
                    m_fall[c]  = ~m_level[c];
                end
                if (req[c] && !prev_req[c]) begin
                    last_rise[c] = edge_no;
                end
                prev_req[c] = req[c];
                m_send[c] = req[c] | ((edge_no - last_rise[c]) < H);
            end
        end
        #1;
        tests++;
        assert (obs_vec() === exp_vec()) else begin
            fails++;
            $error("FAIL model edge %0d observed=%b expected=%b", edge_no, obs_vec(), exp_vec());
        end
    endtask

    int n;
    int at;

    initial begin
        rst = 1'b1;
        receive_connect = 1'b0; receive_start = 1'b0; receive_game_finish = 1'b0;
        tx_connect_req = 1'b0; tx_start_req = 1'b0; tx_finish_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            hist[c] = 32'd0; m_level[c] = 1'b0; m_rise[c] = 1'b0; m_fall[c] = 1'b0;
            m_send[c] = 1'b0; prev_req[c] = 1'b0; last_rise[c] = -1000;
        end
        tick();
        tick();
        tests++;
        assert (obs_vec() === 11'd0) else begin
            fails++;
            $error("FAIL reset_state observed=%b expected=%b", obs_vec(), 11'd0);
        end
        rst = 1'b0;
        tick();

        // Filtered rising edge on start: one pulse at relative edge 6, none while held.
        receive_start = 1'b1;
        n = 0; at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (rx_start_pulse) begin n++; at = i; end
        end
        tests++;
        assert (n === 1 && at === 6) else begin
            fails++;
            $error("FAIL start_pulse observed count=%0d edge=%0d expected count=1 edge=6", n, at);
        end

        // Three-cycle glitch never reaches the finish level.
        receive_game_finish = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rx_finish | rx_finish_pulse) n++;
        end
        receive_game_finish = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rx_finish | rx_finish_pulse) n++;
        end
        tests++;
        assert (n === 0) else begin
            fails++;
            $error("FAIL glitch observed high_cycles=%0d expected=0", n);
        end

        // Single-cycle connect request stretches to exactly H cycles.
        tx_connect_req = 1'b1;
        tick();
        n = send_connect ? 1 : 0;
        tx_connect_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (send_connect) n++;
        end
        tests++;
        assert (n === H) else begin
            fails++;
            $error("FAIL connect_stretch observed=%0d expected=%0d", n, H);
        end

        // Retrigger four cycles later extends the start line to 12 cycles.
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tx_start_req = (i == 1 || i == 5) ? 1'b1 : 1'b0;
            tick();
            if (send_start) n++;
        end
        tx_start_req = 1'b0;
        tests++;
        assert (n === 12) else begin
            fails++;
            $error("FAIL start_retrigger observed=%0d expected=12", n);
        end

        // Link comes up, then peer drop gives one peer_lost after 6 edges.
        receive_connect = 1'b1;
        tx_connect_req  = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        tests++;
        assert (link_up === 1'b1) else begin
            fails++;
            $error("FAIL link_up observed=%b expected=1", link_up);
        end
        receive_connect = 1'b0;
        n = 0; at = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (peer_lost) begin n++; at = i; end
        end
        tests++;
        assert (n === 1 && at === 6 && link_up === 1'b0) else begin
            fails++;
            $error("FAIL peer_lost observed count=%0d edge=%0d link_up=%b expected count=1 edge=6 link_up=0",
                   n, at, link_up);
        end
        tx_connect_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Reset in the middle of a hold clears everything and does not re-raise send.
        tx_finish_req = 1'b1;
        tick();
        tx_finish_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tests++;
        assert (obs_vec() === 11'd0) else begin
            fails++;
            $error("FAIL reset_mid_hold observed=%b expected=%b", obs_vec(), 11'd0);
        end
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (send_game_finish) n++;
        end
        tests++;
        assert (n === 0) else begin
            fails++;
            $error("FAIL no_resend observed=%0d expected=0", n);
        end

        // Randomized traffic on all lines with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) receive_connect     = ~receive_connect;
            if ($urandom_range(0, 4) == 0) receive_start       = ~receive_start;
            if ($urandom_range(0, 3) == 0) receive_game_finish = ~receive_game_finish;
            if ($urandom_range(0, 9) == 0) tx_connect_req      = ~tx_connect_req;
            if ($urandom_range(0, 6) == 0) tx_start_req        = ~tx_start_req;
            if ($urandom_range(0, 3) == 0) tx_finish_req       = ~tx_finish_req;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
